// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - shared defaults, scheduler states and requester id for sigmoid_sched
package sigmoid_pkg;
  localparam int DATA_W_DEF    = 8;
  localparam int TAG_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef logic req_id_t;
endpackage

// File: rtl/sigmoid_tag_fifo.sv
// rtl/sigmoid_tag_fifo.sv - owner-tag FIFO tracking which requester each in-flight core sample belongs to
module sigmoid_tag_fifo
  import sigmoid_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  req_id_t       push_id,
  input  logic          pop,
  output req_id_t       pop_id,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  req_id_t           r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign pop_id  = r_mem[r_rd_ptr];
  // Overflow and underflow are refused here so a misbehaving caller cannot corrupt the pointers.
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_id;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sigmoid_sched.sv
// rtl/sigmoid_sched.sv - round-robin sharing of one in-order sigmoid core between two requesters, with drain/halt
module sigmoid_sched
  import sigmoid_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              core_in_valid,
  output logic [DATA_W-1:0] core_in_data,
  input  logic              core_out_valid,
  input  logic [DATA_W-1:0] core_out_data,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              drain_req,
  input  logic              resume,
  output logic              drained,
  output logic              err
);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  state_e          r_state;
  state_e          w_state_nxt;
  req_id_t         r_last;
  req_id_t         w_pop_id;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_can_grant;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_push;
  logic            w_pop;

  // Full is judged on the registered count, so a pop this cycle does not free a slot until next cycle.
  assign w_can_grant = (r_state == ST_RUN) && !w_full;
  assign w_grant0    = w_can_grant && req0_valid && (!req1_valid || (r_last == 1'b1));
  assign w_grant1    = w_can_grant && req1_valid && (!req0_valid || (r_last == 1'b0));
  assign w_push      = w_grant0 || w_grant1;
  assign w_pop       = core_out_valid && !w_empty;
  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign drained     = (r_state == ST_HALT);

  sigmoid_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .push_id (w_grant1),
    .pop     (w_pop),
    .pop_id  (w_pop_id),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (drain_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if ((w_count == '0) && !core_in_valid) w_state_nxt = ST_HALT;
      ST_HALT:  if (resume) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_last        <= 1'b1;
      core_in_valid <= 1'b0;
      core_in_data  <= '0;
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp_data      <= '0;
      err           <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      core_in_valid <= w_push;
      rsp0_valid    <= w_pop && (w_pop_id == 1'b0);
      rsp1_valid    <= w_pop && (w_pop_id == 1'b1);
      if (w_push) begin
        r_last       <= w_grant1;
        core_in_data <= w_grant1 ? req1_data : req0_data;
      end
      if (w_pop) begin
        rsp_data <= core_out_data;
      end
      // A result with no owner outstanding is dropped and flagged until reset.
      if (core_out_valid && w_empty) begin
        err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sigmoid_sched.sv
// tb/tb_sigmoid_sched.sv - randomized and directed self-checking bench for sigmoid_sched against a queue model
module tb_sigmoid_sched;
  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       core_in_valid;
  logic [7:0] core_in_data;
  logic       core_out_valid;
  logic [7:0] core_out_data;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp_data;
  logic       drain_req, resume;
  logic       drained, err;

  sigmoid_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .core_in_valid(core_in_valid), .core_in_data(core_in_data),
    .core_out_valid(core_out_valid), .core_out_data(core_out_data),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .drain_req(drain_req), .resume(resume), .drained(drained), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 3;
  int inj_req = 0;
  int inj_done = 0;
  bit chk_en = 0;
  bit rnd_mode = 0;

  typedef struct {int due; logic [7:0] d;} core_ent_t;
  core_ent_t  core_q[$];
  logic [7:0] src0[$], src1[$];
  logic [7:0] exp0[$], exp1[$];
  logic [7:0] log0[$], log1[$], cin_log[$];
  int         acc0[$];

  // Model: 0 RUN, 1 DRAIN, 2 HALT; m_q holds owners of samples in flight, oldest first.
  int         m_state = 0;
  int         m_q[$];
  int         m_last = 1;
  logic       m_civ = 0, m_r0 = 0, m_r1 = 0, m_err = 0;
  logic [7:0] m_cid = 0, m_rd = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int winner();
    if (m_state != 0 || m_q.size() >= 4) return -1;
    if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g, n_in, o;
    logic pend;
    if (rst) begin
      m_state = 0; m_q.delete(); m_last = 1;
      m_civ = 0; m_cid = 0; m_r0 = 0; m_r1 = 0; m_rd = 0; m_err = 0;
      exp0.delete(); exp1.delete();
    end else begin
      g = winner();
      n_in = m_q.size();
      pend = m_civ;
      m_r0 = 0; m_r1 = 0;
      if (core_out_valid) begin
        if (m_q.size() > 0) begin
          o = m_q.pop_front();
          if (o == 0) m_r0 = 1; else m_r1 = 1;
          m_rd = core_out_data;
        end else begin
          m_err = 1;
        end
      end
      m_civ = 0;
      if (g >= 0) begin
        m_q.push_back(g);
        m_last = g;
        m_civ = 1;
        m_cid = (g == 1) ? req1_data : req0_data;
        if (g == 0) exp0.push_back(~req0_data); else exp1.push_back(~req1_data);
      end
      case (m_state)
        0: if (drain_req) m_state = 1;
        1: if (n_in == 0 && !pend) m_state = 2;
        2: if (resume) m_state = 0;
        default: m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    int w;
    logic [7:0] e;
    if (chk_en) begin
      w = winner();
      chk("req0_ready", req0_ready, w == 0);
      chk("req1_ready", req1_ready, w == 1);
      chk("core_in_valid", core_in_valid, m_civ);
      chk("core_in_data", core_in_data, m_cid);
      chk("rsp0_valid", rsp0_valid, m_r0);
      chk("rsp1_valid", rsp1_valid, m_r1);
      chk("rsp_data", rsp_data, m_rd);
      chk("drained", drained, m_state == 2);
      chk("err", err, m_err);
      if (rsp0_valid) begin
        log0.push_back(rsp_data);
        if (exp0.size() == 0) chk("rsp0_unexpected", 1, 0);
        else begin e = exp0.pop_front(); chk("rsp0_e2e", rsp_data, e); end
      end
      if (rsp1_valid) begin
        log1.push_back(rsp_data);
        if (exp1.size() == 0) chk("rsp1_unexpected", 1, 0);
        else begin e = exp1.pop_front(); chk("rsp1_e2e", rsp_data, e); end
      end
      if (req0_valid && req0_ready) acc0.push_back(cyc);
      if (core_in_valid) cin_log.push_back(core_in_data);
      if (core_in_valid && !rst) core_q.push_back('{cyc + lat, core_in_data});
    end
  end

  // Requester sources: valid while a sample is queued, data held until accepted.
  always begin
    bit a0, a1, en0, en1;
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clk);
    #2;
    if (a0 && src0.size() > 0) void'(src0.pop_front());
    if (a1 && src1.size() > 0) void'(src1.pop_front());
    en0 = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    en1 = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    req0_valid = (src0.size() > 0) && en0;
    req0_data  = (src0.size() > 0) ? src0[0] : 8'h00;
    req1_valid = (src1.size() > 0) && en1;
    req1_data  = (src1.size() > 0) ? src1[0] : 8'h00;
  end

  // Core model: fixed latency, returns the bitwise inverse of each sample.
  always @(posedge clk) begin
    core_ent_t t;
    #3;
    cyc++;
    if (rst) begin
      core_q.delete();
      core_out_valid = 1'b0;
      core_out_data  = 8'h00;
    end else if (inj_req != inj_done) begin
      inj_done++;
      core_out_valid = 1'b1;
      core_out_data  = 8'h5A;
    end else if (core_q.size() > 0 && core_q[0].due <= cyc) begin
      t = core_q.pop_front();
      core_out_valid = 1'b1;
      core_out_data  = ~t.d;
    end else begin
      core_out_valid = 1'b0;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
    chk({tag, "_civ"}, core_in_valid, 0);
    chk({tag, "_cid"}, core_in_data, 0);
    chk({tag, "_rsp0"}, rsp0_valid, 0);
    chk({tag, "_rsp1"}, rsp1_valid, 0);
    chk({tag, "_rspd"}, rsp_data, 0);
    chk({tag, "_drained"}, drained, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    rst = 1'b1; drain_req = 1'b0; resume = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
    core_out_valid = 1'b0; core_out_data = 8'h00;
    tick(2);
    rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    chk_all_zero("reset");

    tick(1);
    lat = 3;
    cin_log.delete(); log0.delete(); log1.delete();
    for (int i = 0; i < 6; i++) begin
      src0.push_back(8'(i));
      src1.push_back(8'(8'h80 + i));
    end
    tick(30);
    if (cin_log.size() < 4) chk("contention_count", cin_log.size(), 4);
    else begin
      chk("contention_0", cin_log[0], 8'h00);
      chk("contention_1", cin_log[1], 8'h80);
      chk("contention_2", cin_log[2], 8'h01);
      chk("contention_3", cin_log[3], 8'h81);
    end
    chk("contention_rsp0_n", log0.size(), 6);
    chk("contention_rsp1_n", log1.size(), 6);

    log0.delete(); log1.delete();
    src0.push_back(8'h10); src0.push_back(8'h20); src0.push_back(8'h30);
    tick(15);
    chk("single_n", log0.size(), 3);
    if (log0.size() == 3) begin
      chk("single_0", log0[0], 8'hEF);
      chk("single_1", log0[1], 8'hDF);
      chk("single_2", log0[2], 8'hCF);
    end
    chk("single_rsp1_n", log1.size(), 0);

    lat = 8;
    acc0.delete();
    for (int i = 0; i < 6; i++) src0.push_back(8'(8'h40 + i));
    tick(40);
    if (acc0.size() < 5) chk("full_acc_n", acc0.size(), 5);
    else begin
      chk("full_first4", acc0[3] - acc0[0], 3);
      chk("full_reopen", acc0[4] - acc0[0], 10);
    end

    lat = 10;
    log0.delete();
    src0.push_back(8'hA0); src0.push_back(8'hA1); src0.push_back(8'hA2);
    tick(3);
    drain_req = 1'b1;
    tick(1);
    drain_req = 1'b0;
    src0.push_back(8'hB0); src0.push_back(8'hB1);
    tick(30);
    @(negedge clk);
    chk("drain_drained", drained, 1);
    chk("drain_rsp_n", log0.size(), 3);
    chk("halt_valid", req0_valid, 1);
    chk("halt_ready", req0_ready, 0);
    tick(1);
    resume = 1'b1;
    tick(1);
    resume = 1'b0;
    @(negedge clk);
    chk("resume_drained", drained, 0);
    chk("resume_ready", req0_ready, 1);
    tick(30);

    log0.delete(); log1.delete();
    inj_req++;
    tick(2);
    @(negedge clk);
    chk("err_set", err, 1);
    chk("err_no_rsp", log0.size() + log1.size(), 0);
    tick(1);
    src0.push_back(8'h77); src0.push_back(8'h78);
    tick(25);
    chk("err_after_n", log0.size(), 2);
    chk("err_sticky", err, 1);

    rnd_mode = 1;
    lat = $urandom_range(1, 9);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0 && src0.size() < 4) src0.push_back(8'($urandom));
      if ($urandom_range(0, 2) == 0 && src1.size() < 4) src1.push_back(8'($urandom));
      drain_req = ($urandom_range(0, 39) == 0);
      resume    = ($urandom_range(0, 7) == 0);
      tick(1);
    end
    drain_req = 1'b0;
    rnd_mode = 0;
    src0.delete(); src1.delete();
    repeat (3) begin
      resume = 1'b1;
      tick(1);
      resume = 1'b0;
      tick(20);
    end

    lat = 8;
    src0.push_back(8'h11); src0.push_back(8'h12);
    tick(4);
    src0.delete(); src1.delete();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    tick(1);
    src0.push_back(8'h21);
    src1.push_back(8'hA1);
    @(negedge clk);
    chk("midrst_both", req0_valid && req1_valid, 1);
    chk("midrst_win0", req0_ready, 1);
    chk("midrst_win1", req1_ready, 0);
    tick(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
